// File: rtl/accel_sketch_sw_debounce.sv
// Two-flop synchroniser plus independent per-bit debounce counters for the slide switches.
// A bit's clean level changes only after DEBOUNCE_CYCLES consecutive mismatching samples.
module accel_sketch_sw_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    state_t           state   [WIDTH];
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    // The counter doubles as the state register: a non-zero count means PENDING.
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state[i] = (cnt[i] == '0) ? STABLE : PENDING;
        end
    end

    always_comb begin
        clean_nxt = sw_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            case (state[i])
                STABLE: begin
                    if (s2[i] != sw_clean[i]) begin
                        if (cnt[i] == CNT_LAST) begin
                            clean_nxt[i] = s2[i];
                            rise_nxt[i]  = s2[i];
                            fall_nxt[i]  = ~s2[i];
                        end else begin
                            cnt_nxt[i] = cnt[i] + CNT_W'(1);
                        end
                    end
                end
                PENDING: begin
                    if (s2[i] == sw_clean[i]) begin
                        cnt_nxt[i] = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        clean_nxt[i] = s2[i];
                        rise_nxt[i]  = s2[i];
                        fall_nxt[i]  = ~s2[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: cnt_nxt[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= '0;
            s2       <= '0;
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= sw_raw;
            s2       <= s1;
            sw_clean <= clean_nxt;
            sw_rise  <= rise_nxt;
            sw_fall  <= fall_nxt;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_accel_sketch_sw_debounce.sv
// Scoreboard bench for the switch debouncer: a cycle model queues expected outputs per edge,
// and directed checks pin the latencies of each scenario.
module tb_accel_sketch_sw_debounce;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;

    accel_sketch_sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3*W-1:0] exp_q [$];

    // Reference: sync pipe of two samples, then a run length of mismatching samples per bit.
    logic [W-1:0] m_p1, m_p2, m_clean, m_rise, m_fall;
    int           m_run [W];
    logic [W-1:0] acc_pulse5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] raw);
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (m_p2[i] === m_clean[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == D) begin
                    m_clean[i] = m_p2[i];
                    if (m_p2[i]) m_rise[i] = 1'b1;
                    else         m_fall[i] = 1'b1;
                    m_run[i] = 0;
                end
            end
        end
        m_p2 = m_p1;
        m_p1 = raw;
    endtask

    // One clock: drive, model the edge and queue the expectation, compare on the falling edge.
    task automatic step(input logic [W-1:0] raw, input logic rst);
        logic [3*W-1:0] e;
        sw_raw  = raw;
        reset_n = rst;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge(raw);
        exp_q.push_back({m_clean, m_rise, m_fall});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("sb_out", 32'({sw_clean, sw_rise, sw_fall}), 32'(e));
        end
        acc_pulse5 = acc_pulse5 | ((sw_rise | sw_fall) & 10'h020);
    endtask

    task automatic steps(input logic [W-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b1);
    endtask

    initial begin
        logic [W-1:0] pat;
        acc_pulse5 = '0;
        model_reset();
        sw_raw  = '0;
        reset_n = 1'b0;

        // 1: reset hold with all switches high, then release
        for (int k = 0; k < 3; k++) step(10'h3FF, 1'b0);
        check("rst_clean", 32'(sw_clean), 32'h0);
        check("rst_pulses", 32'({sw_rise, sw_fall}), 32'h0);
        steps(10'h3FF, 5);                       // edges 0..4
        check("rel_e4_clean", 32'(sw_clean), 32'h0);
        steps(10'h3FF, 1);                       // edge 5
        check("rel_e5_clean", 32'(sw_clean), 32'h3FF);
        check("rel_e5_rise", 32'(sw_rise), 32'h3FF);
        steps(10'h3FF, 1);
        check("rel_e6_rise", 32'(sw_rise), 32'h0);

        // 2: clean step on bit 0 from an all-zero state
        steps(10'h000, 8);
        check("zero_clean", 32'(sw_clean), 32'h0);
        steps(10'h001, 5);
        check("step_e4_clean", 32'(sw_clean), 32'h0);
        steps(10'h001, 1);
        check("step_e5_clean", 32'(sw_clean), 32'h001);
        check("step_e5_rise", 32'(sw_rise), 32'h001);
        steps(10'h001, 1);
        check("step_e6_rise", 32'(sw_rise), 32'h0);

        // 3: bounce on bit 3 is rejected, then a sustained run is accepted
        pat = 10'h001;
        step(pat | 10'h008, 1'b1);
        step(pat,           1'b1);
        step(pat | 10'h008, 1'b1);
        step(pat | 10'h008, 1'b1);
        step(pat,           1'b1);
        steps(pat, 8);
        check("bounce_clean", 32'(sw_clean), 32'h001);
        steps(10'h009, 5);
        check("run_e4_clean", 32'(sw_clean), 32'h001);
        steps(10'h009, 1);
        check("run_e5_clean", 32'(sw_clean), 32'h009);
        check("run_e5_rise", 32'(sw_rise), 32'h008);

        // 4: simultaneous rise and fall on several bits
        steps(10'h0F0, 8);
        check("pre4_clean", 32'(sw_clean), 32'h0F0);
        steps(10'h00F, 5);
        check("mb_e4_clean", 32'(sw_clean), 32'h0F0);
        steps(10'h00F, 1);
        check("mb_e5_clean", 32'(sw_clean), 32'h00F);
        check("mb_e5_rise", 32'(sw_rise), 32'h00F);
        check("mb_e5_fall", 32'(sw_fall), 32'h0F0);
        steps(10'h00F, 1);
        check("mb_e6_pulses", 32'({sw_rise, sw_fall}), 32'h0);

        // 5: reset in the middle of a pending count on bit 9
        steps(10'h20F, 3);
        step(10'h20F, 1'b0);
        check("midrst_clean", 32'(sw_clean), 32'h0);
        step(10'h20F, 1'b0);
        steps(10'h20F, 5);
        check("midrst_e4_clean", 32'(sw_clean), 32'h0);
        steps(10'h20F, 1);
        check("midrst_e5_clean", 32'(sw_clean), 32'h20F);
        check("midrst_e5_rise", 32'(sw_rise), 32'h20F);

        // 6: bit 5 toggling every 3 cycles never settles
        steps(10'h20F, 2);
        acc_pulse5 = '0;
        pat = 10'h20F;
        for (int c = 0; c < 100; c++) begin
            if (c % 3 == 0) pat[5] = ~pat[5];
            step(pat, 1'b1);
        end
        check("toggle_clean", 32'(sw_clean), 32'h20F);
        check("toggle_pulses", 32'(acc_pulse5), 32'h0);

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
